node_integrator: RTL and testbench

NODE_INTEGRATOR -- requirements
Module: node_integrator

---
 rtl/node_integrator_if.sv | 27 ++
 rtl/node_integrator.sv | 123 ++++++++++++
 tb/tb_node_integrator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/node_integrator_if.sv
// Contribution stream, preload and node-state bundle for one node integrator.
// master drives contributions/preloads; slave (the integrator) returns node state.
interface node_integrator_if #(
    parameter int W = 16
);
    logic                i_valid;
    logic signed [W-1:0] i_data;
    logic                i_last;
    logic                i_ready;
    logic                ld_valid;
    logic signed [W-1:0] ld_v;
    logic signed [W-1:0] v;
    logic                v_valid;
    logic                p;
    logic                settled;
    logic                err;

    modport master (
        output i_valid, i_data, i_last, ld_valid, ld_v,
        input  i_ready, v, v_valid, p, settled, err
    );

    modport slave (
        input  i_valid, i_data, i_last, ld_valid, ld_v,
        output i_ready, v, v_valid, p, settled, err
    );
endinterface

// File: rtl/node_integrator.sv
// Sums current contributions per sweep and integrates them into a clamped node voltage.
// v lands 2 edges after the i_last beat; i_ready drops for the UPDATE cycle and while ld_valid is high.
module node_integrator #(
    parameter int W     = 16,
    parameter int VHI   = 16384,
    parameter int VLO   = -16384,
    parameter int SHIFT = 0,
    parameter int THR   = 4,
    parameter int SCNT  = 8
) (
    input  logic               eclk,
    input  logic               erst,
    node_integrator_if.slave   bus
);
    localparam int AW = W + 8;
    localparam int SW = W + 9;
    localparam int CW = $clog2(SCNT + 1);

    localparam logic signed [AW:0]   ACC_MAX = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0]   ACC_MIN = {2'b11, {(AW-1){1'b0}}};
    localparam logic signed [SW-1:0] VHI_S   = SW'(VHI);
    localparam logic signed [SW-1:0] VLO_S   = SW'(VLO);
    localparam logic signed [W-1:0]  VHI_W   = W'(VHI);
    localparam logic signed [W-1:0]  VLO_W   = W'(VLO);
    localparam logic signed [W:0]    THR_D   = (W+1)'(THR);
    localparam logic [CW-1:0]        SCNT_C  = CW'(SCNT);

    typedef enum logic {ACCUM, UPDATE} state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q;
    logic [8:0]           cnt_q;
    logic [CW-1:0]        scnt_q;
    logic signed [W-1:0]  v_q;
    logic                 v_valid_q;
    logic                 settled_q;
    logic                 err_q;

    logic                 accept;
    logic signed [AW:0]   acc_sum;
    logic signed [AW-1:0] acc_sat;
    logic signed [SW-1:0] v_sum;
    logic signed [W-1:0]  v_new;
    logic signed [W-1:0]  ld_clamp;
    logic signed [W:0]    dv;
    logic signed [W:0]    adv;
    logic [CW-1:0]        scnt_d;

    assign bus.i_ready = (state_q == ACCUM) && !bus.ld_valid;
    assign accept      = bus.i_valid && bus.i_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && bus.i_last) state_d = UPDATE;
            UPDATE:  state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // One extra bit of headroom lets the accumulator saturate instead of wrapping.
    always_comb begin
        acc_sum = (AW+1)'(acc_q) + (AW+1)'(bus.i_data);
        acc_sat = acc_sum[AW-1:0];
        if (acc_sum > ACC_MAX)      acc_sat = ACC_MAX[AW-1:0];
        else if (acc_sum < ACC_MIN) acc_sat = ACC_MIN[AW-1:0];
    end

    always_comb begin
        v_sum = SW'(v_q) + SW'(acc_q >>> SHIFT);
        v_new = v_sum[W-1:0];
        if (v_sum > VHI_S)      v_new = VHI_W;
        else if (v_sum < VLO_S) v_new = VLO_W;

        ld_clamp = bus.ld_v;
        if (bus.ld_v > VHI_W)      ld_clamp = VHI_W;
        else if (bus.ld_v < VLO_W) ld_clamp = VLO_W;

        dv  = (W+1)'(v_new) - (W+1)'(v_q);
        adv = (dv < 0) ? -dv : dv;
        if (adv <= THR_D) scnt_d = (scnt_q == SCNT_C) ? scnt_q : scnt_q + CW'(1);
        else              scnt_d = '0;
    end

    always_ff @(posedge eclk or posedge erst) begin
        if (erst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            scnt_q    <= '0;
            v_q       <= VLO_W;
            v_valid_q <= 1'b0;
            settled_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_valid_q <= 1'b0;
            if (state_q == UPDATE) begin
                v_q       <= v_new;
                v_valid_q <= 1'b1;
                acc_q     <= '0;
                cnt_q     <= '0;
                scnt_q    <= scnt_d;
                settled_q <= (scnt_d == SCNT_C);
            end else if (bus.ld_valid) begin
                v_q       <= ld_clamp;
                scnt_q    <= '0;
                settled_q <= 1'b0;
            end else if (accept) begin
                acc_q <= acc_sat;
                // cnt_q[8] means 256 beats already taken, so this one overruns the sweep.
                if (cnt_q[8]) err_q <= 1'b1;
                if (cnt_q != 9'h1FF) cnt_q <= cnt_q + 9'd1;
            end
        end
    end

    assign bus.v       = v_q;
    assign bus.v_valid = v_valid_q;
    assign bus.p       = ~v_q[W-1];
    assign bus.settled = settled_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_node_integrator.sv
// Directed-vector bench for node_integrator at default parameters.
module tb_node_integrator;
    logic eclk = 1'b0;
    logic erst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 eclk = ~eclk;

    node_integrator_if #(.W(16)) bus ();

    node_integrator #(
        .W(16), .VHI(16384), .VLO(-16384), .SHIFT(0), .THR(4), .SCNT(8)
    ) dut (
        .eclk (eclk),
        .erst (erst),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic rst();
        erst = 1'b1;
        @(negedge eclk);
        @(negedge eclk);
        erst = 1'b0;
        #1;
        chk("rst_v", bus.v, -16384);
        chk("rst_p", bus.p, 0);
        chk("rst_vv", bus.v_valid, 0);
        chk("rst_settled", bus.settled, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_ready", bus.i_ready, 1);
    endtask

    // Holds the beat until a rising edge with i_ready high; returns at posedge+1.
    task automatic send(input logic signed [15:0] d, input logic l);
        int   n;
        logic rdy;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = l;
        n = 0;
        do begin
            #1;
            rdy = bus.i_ready;
            @(posedge eclk);
            n++;
        end while (!rdy && n < 20);
        if (!rdy) chk("send_timeout", 0, 1);
        #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic wait_vv(input string tag);
        int n;
        n = 0;
        @(negedge eclk);
        while (!bus.v_valid && n < 8) begin
            n++;
            @(negedge eclk);
        end
        chk(tag, bus.v_valid, 1);
    endtask

    task automatic ld(input logic signed [15:0] val);
        bus.ld_valid = 1'b1;
        bus.ld_v     = val;
        @(posedge eclk);
        #1;
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_last   = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_v     = '0;
        rst();

        // Three-beat sweep: one stall cycle, then a single v_valid pulse.
        send(16'sd100, 1'b0);
        send(16'sd200, 1'b0);
        send(-16'sd50, 1'b1);
        @(negedge eclk);
        chk("upd_ready", bus.i_ready, 0);
        chk("upd_vv", bus.v_valid, 0);
        @(negedge eclk);
        chk("sweep_v", bus.v, -16134);
        chk("sweep_vv", bus.v_valid, 1);
        chk("sweep_ready", bus.i_ready, 1);
        @(negedge eclk);
        chk("sweep_vv_drop", bus.v_valid, 0);

        // Preload near the rail, then overdrive into the upper clamp.
        ld(16'sd16000);
        chk("ld_v", bus.v, 16000);
        chk("ld_vv", bus.v_valid, 0);
        send(16'sd32767, 1'b1);
        wait_vv("clamp_vv");
        chk("clamp_v", bus.v, 16384);
        chk("clamp_p", bus.p, 1);

        // Quiet sweeps build up to settled; a large step knocks it down.
        ld(16'sd0);
        for (int i = 1; i <= 8; i++) begin
            send(16'sd3, 1'b1);
            wait_vv("quiet_vv");
            if (i == 7) chk("settle7", bus.settled, 0);
        end
        chk("settle8", bus.settled, 1);
        chk("quiet_v", bus.v, 24);
        send(16'sd10, 1'b1);
        wait_vv("loud_vv");
        chk("loud_settled", bus.settled, 0);
        chk("loud_v", bus.v, 34);
        for (int i = 0; i < 7; i++) begin
            send(16'sd1, 1'b1);
            wait_vv("pre_ld_vv");
        end
        chk("pre_ld_v", bus.v, 41);

        // Preload collides with a contribution: preload wins, beat retried.
        bus.ld_valid = 1'b1;
        bus.ld_v     = 16'sd1000;
        bus.i_valid  = 1'b1;
        bus.i_data   = 16'sd2;
        bus.i_last   = 1'b1;
        #1;
        chk("coll_ready", bus.i_ready, 0);
        @(posedge eclk);
        #1;
        bus.ld_valid = 1'b0;
        chk("coll_v", bus.v, 1000);
        @(negedge eclk);
        chk("coll_vv", bus.v_valid, 0);
        chk("coll_ready2", bus.i_ready, 1);
        @(posedge eclk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        wait_vv("retry_vv");
        chk("retry_v", bus.v, 1002);
        chk("retry_settled", bus.settled, 0);

        // Reset mid-sweep throws away the partial sum.
        send(16'sd100, 1'b0);
        send(16'sd200, 1'b0);
        rst();
        send(16'sd5, 1'b1);
        wait_vv("midrst_vv");
        chk("midrst_v", bus.v, -16379);

        // Reset during UPDATE: no update, no pulse.
        send(16'sd100, 1'b1);
        rst();
        @(negedge eclk);
        chk("updrst_vv", bus.v_valid, 0);
        chk("updrst_v", bus.v, -16384);

        // 257th beat in one sweep raises the sticky error.
        for (int i = 0; i < 256; i++) send(16'sd1, 1'b0);
        chk("err256", bus.err, 0);
        send(16'sd1, 1'b0);
        chk("err257", bus.err, 1);
        send(16'sd1, 1'b1);
        wait_vv("long_vv");
        chk("long_v", bus.v, -16126);
        chk("err_sticky", bus.err, 1);

        // Accumulator overflow must saturate positive rather than wrap negative.
        ld(16'sd0);
        for (int i = 0; i < 259; i++) send(16'sd32767, 1'b0);
        send(16'sd32767, 1'b1);
        wait_vv("sat_vv");
        chk("sat_v", bus.v, 16384);
        chk("sat_err", bus.err, 1);
        rst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
